psram_mem_bridge: RTL and testbench
===================================

Name: psram_mem_bridge

Overview:
- Responder on the core's data-memory port.
- Accepts one 32-bit load/store per instruction, addressed in bytes with a byte/half/word size.
- Splits each request into one or two 16-bit transactions on the psram controller's command interface.
- Holds the core stalled until the access finishes, then returns load data or an error for one cycle.

Parameters:
- ADDR_BITS, 23: byte-address bits forwarded. The psram word address is addr[ADDR_BITS-1:1].
- TIMEOUT_CYCLES, 1024: maximum wait per 16-bit transaction before the request is aborted with an error.
- BANK, 0: constant driven on bank_sel.

Ports:
- clk  in  1  clock
- reset_n  in  1  async active-low reset
- req_valid  in  1  core presents a memory op; fields stable while stall=1
- req_we  in  1  1=store, 0=load
- req_addr  in  32  byte address
- req_wdata  in  32  store data, LSB-aligned
- req_size  in  2  ram_mask_e: byte/half/word
- stall  out  1  core must hold pc and request
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  load data, zero-extended; valid with rsp_valid
- rsp_err  out  1  misaligned or timeout; valid with rsp_valid
- bank_sel  out  1  psram bank
- ps_addr  out  22  psram 16-bit word address
- ps_write_en  out  1  one-cycle write command
- ps_data_in  out  16  write data
- ps_write_high_byte  out  1  upper lane enable
- ps_write_low_byte  out  1  lower lane enable
- ps_read_en  out  1  one-cycle read command
- ps_read_avail  in  1  read data valid pulse
- ps_data_out  in  16  read data
- ps_busy  in  1  controller busy

Behaviour:
- Clock and reset: clk; reset_n is asynchronous, active-low.
- Reset: state=IDLE; all outputs 0 except bank_sel=BANK; timeout counter 0.
- Async reset mid-transaction abandons the op; no completion pulse is produced.
- States: IDLE, ISSUE_LO, WAIT_LO, ISSUE_HI, WAIT_HI, DONE.
- stall is combinational: (IDLE & req_valid) | (state not in {IDLE, DONE}).
- IDLE, req_valid=1: latch request.
  - Misaligned (word with addr[1:0]!=0, half with addr[0]!=0): go to DONE with err=1; no psram command.
  - Otherwise go to ISSUE_LO.
- ISSUE_x: wait for ps_busy=0, then pulse ps_read_en or ps_write_en for exactly one cycle; go to WAIT_x.
  - Commands are never issued while busy=1.
- Address: ps_addr = addr[ADDR_BITS-1:1] for the LO transaction, +1 for the HI transaction (word only).
- Byte-lane steering on the LO transaction:
  - Word/half: both lanes enabled; data = wdata[15:0].
  - Byte: the high lane is enabled iff addr[0]=1; data = {wdata[7:0], wdata[7:0]}.
- HI transaction (word only): both lanes enabled; data = wdata[31:16].
- WAIT_x, read: capture ps_data_out on ps_read_avail.
- WAIT_x, write: complete on the first cycle with ps_busy=0, at least one cycle after the command.
- WAIT_x exit: word LO goes to ISSUE_HI; everything else goes to DONE.
- Timeout: the counter resets on entry to each WAIT state.
  - When the count reaches TIMEOUT_CYCLES, go to DONE with err=1 and rdata=0.
  - A timeout in WAIT_LO skips the HI transaction.
- DONE: rsp_valid=1 for one cycle; stall=0; next state is IDLE.
  - A request presented in IDLE the following cycle is accepted immediately; no dead cycle is required beyond DONE.
- rdata assembly:
  - Word: {hi16, lo16}.
  - Half: {16'b0, lo16}.
  - Byte: {24'b0, addr[0] ? lo16[15:8] : lo16[7:0]}.
- Sign extension is the core's responsibility.
- A read_avail outside WAIT states is ignored.
- rsp_rdata and rsp_err are registered and hold until the next DONE.
- Store latency with an idle controller: IDLE to DONE is 3 cycles for byte/half and 5 for word, plus controller busy time.

Decomposition:
- Shared rv32i package: bridge_state_e and the reuse of ram_mask_e for req_size.
- Sub-module psram_lane_pack (combinational) computes:
  - ps_data_in and the lane enables from size, addr[0] and phase;
  - rsp_rdata assembly from the captured halves.
- The FSM and counters stay in psram_mem_bridge.

Test Plan:
- Word store 0xDEADBEEF @0x100, controller busy for 4 cycles after each write:
  - writes 0xBEEF to word 0x80, then 0xDEAD to 0x81, both lanes;
  - stall drops with rsp_valid, err=0.
- Word load @0x100, controller returns 0xBEEF then 0xDEAD after 3-cycle latency each -> rsp_rdata=0xDEADBEEF, single rsp_valid pulse.
- Byte store 0x5A @0x203 -> one write, ps_addr=0x101, high=1, low=0, data=0x5A5A. Then byte load @0x203 with data_out=0x5A11 -> rdata=0x0000005A.
- Misaligned half load @0x101 and word store @0x102 -> no ps_read_en/ps_write_en; rsp_err=1 one cycle after req_valid.
- Word load with read_avail never asserted, TIMEOUT_CYCLES=16 -> err=1 after 16 wait cycles; no HI read issued; rdata=0.
- reset_n pulsed low during WAIT_HI -> outputs 0 immediately; no rsp_valid. A subsequent half load completes normally.

Source files
------------

// File: rtl/psram_mem_bridge_pkg.sv
// psram_mem_bridge_pkg
// Shared types for the core data-memory to psram bridge:
//   ram_mask_e     - access size carried on req_size (byte/half/word)
//   bridge_state_e - bridge FSM states
// Helpers:
//   norm_size      - maps the unused size code onto a word access
//   is_misaligned  - natural-alignment check for a given size
package psram_mem_bridge_pkg;

  typedef enum logic [1:0] {
    MASK_BYTE = 2'b00,
    MASK_HALF = 2'b01,
    MASK_WORD = 2'b10
  } ram_mask_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE_LO,
    ST_WAIT_LO,
    ST_ISSUE_HI,
    ST_WAIT_HI,
    ST_DONE
  } bridge_state_e;

  // Size code 2'b11 is not produced by the core; treating it as a word keeps
  // the alignment check, transaction count and rdata assembly consistent.
  function automatic ram_mask_e norm_size(input logic [1:0] size);
    if (size == 2'b11) return MASK_WORD;
    return ram_mask_e'(size);
  endfunction

  function automatic logic is_misaligned(input ram_mask_e size, input logic [1:0] addr_lo);
    case (size)
      MASK_WORD: return (addr_lo != 2'b00);
      MASK_HALF: return addr_lo[0];
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/psram_mem_bridge_lane_pack.sv
// psram_lane_pack
// Combinational byte-lane steering between the 32-bit core port and the
// 16-bit psram data path.
//   size_i       access size
//   addr0_i      byte address bit 0
//   phase_hi_i   1 while issuing the upper half of a word
//   wdata_i      store data, LSB-aligned
//   lo16_i/hi16_i  read halves (lower/upper psram word)
//   data_o       psram write data
//   we_high_o/we_low_o  psram lane enables
//   rdata_o      zero-extended load data
module psram_lane_pack
  import psram_mem_bridge_pkg::*;
(
  input  ram_mask_e   size_i,
  input  logic        addr0_i,
  input  logic        phase_hi_i,
  input  logic [31:0] wdata_i,
  input  logic [15:0] lo16_i,
  input  logic [15:0] hi16_i,
  output logic [15:0] data_o,
  output logic        we_high_o,
  output logic        we_low_o,
  output logic [31:0] rdata_o
);

  always_comb begin
    data_o    = wdata_i[15:0];
    we_high_o = 1'b1;
    we_low_o  = 1'b1;
    if (phase_hi_i) begin
      data_o = wdata_i[31:16];
    end else if (size_i == MASK_BYTE) begin
      // Byte replicated on both lanes so the enabled lane always carries it.
      data_o    = {wdata_i[7:0], wdata_i[7:0]};
      we_high_o = addr0_i;
      we_low_o  = ~addr0_i;
    end
  end

  always_comb begin
    case (size_i)
      MASK_BYTE: rdata_o = {24'b0, (addr0_i ? lo16_i[15:8] : lo16_i[7:0])};
      MASK_HALF: rdata_o = {16'b0, lo16_i};
      default:   rdata_o = {hi16_i, lo16_i};
    endcase
  end

endmodule

// File: rtl/psram_mem_bridge.sv
// psram_mem_bridge
// Responder on the core data-memory port. Each load/store is split into one
// (byte/half) or two (word) 16-bit psram transactions; the core is stalled
// until the access finishes, then rsp_valid_o pulses for one cycle.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | waiting for req_valid_i; misaligned requests go to DONE
// ISSUE_LO  | wait for !ps_busy_i, pulse command for the lower half
// WAIT_LO   | wait for read data / write completion, with timeout
// ISSUE_HI  | word only: command for the upper half (address + 1)
// WAIT_HI   | word only: wait for upper half, with timeout
// DONE      | rsp_valid_o high for one cycle, stall released
//
// Ports:
//   clk, reset_n                   clock, async active-low reset
//   req_*_i                        core request (held while stall_o=1)
//   stall_o                        combinational core stall
//   rsp_valid_o/rsp_rdata_o/rsp_err_o  registered completion
//   bank_sel_o                     constant BANK
//   ps_*_o / ps_*_i                psram controller command interface
module psram_mem_bridge
  import psram_mem_bridge_pkg::*;
#(
  parameter int unsigned ADDR_BITS      = 23,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic        BANK           = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid_i,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [1:0]  req_size_i,
  output logic        stall_o,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        bank_sel_o,
  output logic [21:0] ps_addr_o,
  output logic        ps_write_en_o,
  output logic [15:0] ps_data_in_o,
  output logic        ps_write_high_byte_o,
  output logic        ps_write_low_byte_o,
  output logic        ps_read_en_o,
  input  logic        ps_read_avail_i,
  input  logic [15:0] ps_data_out_i,
  input  logic        ps_busy_i
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  bridge_state_e          state_q;
  logic                   we_q;
  logic [ADDR_BITS-1:0]   addr_q;
  logic [31:0]            wdata_q;
  ram_mask_e              size_q;
  logic [15:0]            lo16_q;
  logic [15:0]            hi16_q;
  logic [CW-1:0]          tmo_cnt_q;

  logic                   ps_write_en_q;
  logic                   ps_read_en_q;
  logic [21:0]            ps_addr_q;
  logic [15:0]            ps_data_in_q;
  logic                   ps_whb_q;
  logic                   ps_wlb_q;
  logic                   rsp_valid_q;
  logic [31:0]            rsp_rdata_q;
  logic                   rsp_err_q;

  logic [21:0]            base_addr;
  logic                   phase_hi;
  logic [15:0]            lo16_d;
  logic [15:0]            hi16_d;
  logic [15:0]            pack_data;
  logic                   pack_whb;
  logic                   pack_wlb;
  logic [31:0]            pack_rdata;
  logic                   xfer_done;
  ram_mask_e              req_size_n;

  generate
    if (ADDR_BITS < 32) begin : g_addr_unused
      logic unused_addr_hi;
      assign unused_addr_hi = ^req_addr_i[31:ADDR_BITS];
    end
  endgenerate

  assign base_addr  = 22'(addr_q[ADDR_BITS-1:1]);
  assign phase_hi   = (state_q == ST_ISSUE_HI);
  assign req_size_n = norm_size(req_size_i);

  // Present the half being captured this cycle so rdata is correct on the
  // same edge that enters DONE.
  assign lo16_d = (state_q == ST_WAIT_LO) ? ps_data_out_i : lo16_q;
  assign hi16_d = (state_q == ST_WAIT_HI) ? ps_data_out_i : hi16_q;

  // A write is complete once the controller is idle in the cycle after the
  // command was registered; a read completes on its data strobe.
  assign xfer_done = we_q ? ~ps_busy_i : ps_read_avail_i;

  psram_lane_pack u_lane_pack (
    .size_i     (size_q),
    .addr0_i    (addr_q[0]),
    .phase_hi_i (phase_hi),
    .wdata_i    (wdata_q),
    .lo16_i     (lo16_d),
    .hi16_i     (hi16_d),
    .data_o     (pack_data),
    .we_high_o  (pack_whb),
    .we_low_o   (pack_wlb),
    .rdata_o    (pack_rdata)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      we_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      size_q        <= MASK_BYTE;
      lo16_q        <= '0;
      hi16_q        <= '0;
      tmo_cnt_q     <= '0;
      ps_write_en_q <= 1'b0;
      ps_read_en_q  <= 1'b0;
      ps_addr_q     <= '0;
      ps_data_in_q  <= '0;
      ps_whb_q      <= 1'b0;
      ps_wlb_q      <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
    end else begin
      ps_write_en_q <= 1'b0;
      ps_read_en_q  <= 1'b0;
      rsp_valid_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_valid_i) begin
            we_q    <= req_we_i;
            addr_q  <= req_addr_i[ADDR_BITS-1:0];
            wdata_q <= req_wdata_i;
            size_q  <= req_size_n;
            lo16_q  <= '0;
            hi16_q  <= '0;
            if (is_misaligned(req_size_n, req_addr_i[1:0])) begin
              state_q     <= ST_DONE;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
            end else begin
              state_q <= ST_ISSUE_LO;
            end
          end
        end
        ST_ISSUE_LO, ST_ISSUE_HI: begin
          if (!ps_busy_i) begin
            ps_addr_q     <= phase_hi ? (base_addr + 22'd1) : base_addr;
            ps_data_in_q  <= pack_data;
            ps_whb_q      <= pack_whb;
            ps_wlb_q      <= pack_wlb;
            ps_write_en_q <= we_q;
            ps_read_en_q  <= ~we_q;
            tmo_cnt_q     <= '0;
            state_q       <= phase_hi ? ST_WAIT_HI : ST_WAIT_LO;
          end
        end
        ST_WAIT_LO, ST_WAIT_HI: begin
          if (xfer_done) begin
            if (!we_q) begin
              if (state_q == ST_WAIT_LO) lo16_q <= ps_data_out_i;
              else                       hi16_q <= ps_data_out_i;
            end
            if (state_q == ST_WAIT_LO && size_q == MASK_WORD) begin
              state_q <= ST_ISSUE_HI;
            end else begin
              state_q     <= ST_DONE;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b0;
              rsp_rdata_q <= we_q ? 32'h0 : pack_rdata;
            end
          end else if (tmo_cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
            // Abort straight to DONE; a lower-half timeout skips the upper half.
            state_q     <= ST_DONE;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= '0;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + CW'(1);
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Gated by reset_n so the core sees no stall while the bridge is held in reset.
  assign stall_o = reset_n &
                   (((state_q == ST_IDLE) & req_valid_i) |
                    ((state_q != ST_IDLE) & (state_q != ST_DONE)));

  assign bank_sel_o           = BANK;
  assign rsp_valid_o          = rsp_valid_q;
  assign rsp_rdata_o          = rsp_rdata_q;
  assign rsp_err_o            = rsp_err_q;
  assign ps_addr_o            = ps_addr_q;
  assign ps_write_en_o        = ps_write_en_q;
  assign ps_data_in_o         = ps_data_in_q;
  assign ps_write_high_byte_o = ps_whb_q;
  assign ps_write_low_byte_o  = ps_wlb_q;
  assign ps_read_en_o         = ps_read_en_q;

endmodule

// File: tb/tb_psram_mem_bridge.sv
`timescale 1ns/1ps
module tb_psram_mem_bridge;
  import psram_mem_bridge_pkg::*;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [1:0]  req_size = '0;
  logic        stall_o, rsp_valid_o, rsp_err_o, bank_sel_o;
  logic [31:0] rsp_rdata_o;
  logic [21:0] ps_addr_o;
  logic        ps_write_en_o, ps_write_high_byte_o, ps_write_low_byte_o, ps_read_en_o;
  logic [15:0] ps_data_in_o;
  logic        ps_read_avail = 1'b0;
  logic [15:0] ps_data_out = '0;
  logic        ps_busy = 1'b0;

  always #5 clk = ~clk;

  psram_mem_bridge #(.ADDR_BITS(23), .TIMEOUT_CYCLES(TMO), .BANK(1'b0)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid_i(req_valid), .req_we_i(req_we), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata), .req_size_i(req_size),
    .stall_o(stall_o), .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o), .bank_sel_o(bank_sel_o),
    .ps_addr_o(ps_addr_o), .ps_write_en_o(ps_write_en_o), .ps_data_in_o(ps_data_in_o),
    .ps_write_high_byte_o(ps_write_high_byte_o), .ps_write_low_byte_o(ps_write_low_byte_o),
    .ps_read_en_o(ps_read_en_o), .ps_read_avail_i(ps_read_avail),
    .ps_data_out_i(ps_data_out), .ps_busy_i(ps_busy)
  );

  int vectors = 0, miscompares = 0;

  // psram controller model: 16-bit word memory, write busy time, read latency
  logic [15:0] cmem [int];
  int          wr_busy = 0, rd_lat = 1;
  bit          no_avail = 0;
  int          busy_rem = 0, rd_wait = 0;
  bit          rd_pend = 0;
  logic [15:0] rd_data = '0;
  int          n_writes = 0, n_reads = 0, cmd_viol = 0;
  typedef struct {logic [21:0] a; logic [15:0] d; logic hb; logic lb;} wr_t;
  wr_t         wr_log[$];

  always @(posedge clk) begin
    int a;
    logic [15:0] w;
    #1;
    ps_read_avail = 1'b0;
    if (!reset_n) begin
      busy_rem = 0;
      rd_pend  = 0;
    end else begin
      if ((ps_write_en_o || ps_read_en_o) && ps_busy) cmd_viol++;
      if (busy_rem > 0) busy_rem--;
      if (rd_pend) begin
        if (rd_wait == 0) begin
          ps_read_avail = 1'b1;
          ps_data_out   = rd_data;
          rd_pend       = 0;
        end else rd_wait--;
      end
      if (ps_write_en_o) begin
        a = int'(ps_addr_o);
        w = cmem.exists(a) ? cmem[a] : 16'h0;
        if (ps_write_low_byte_o)  w[7:0]  = ps_data_in_o[7:0];
        if (ps_write_high_byte_o) w[15:8] = ps_data_in_o[15:8];
        cmem[a] = w;
        n_writes++;
        wr_log.push_back('{ps_addr_o, ps_data_in_o, ps_write_high_byte_o, ps_write_low_byte_o});
        busy_rem = wr_busy;
      end
      if (ps_read_en_o) begin
        a = int'(ps_addr_o);
        n_reads++;
        if (!no_avail) begin
          rd_pend = 1;
          rd_wait = rd_lat - 1;
          rd_data = cmem.exists(a) ? cmem[a] : 16'h0;
        end
      end
    end
    ps_busy = (busy_rem > 0) || rd_pend;
  end

  // Reference model: little-endian byte-addressed memory
  logic [7:0] rmem [int];

  function automatic int nbytes(input logic [1:0] s);
    if (s == 2'b00) return 1;
    if (s == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit ref_misaligned(input logic [31:0] a, input logic [1:0] s);
    return (int'(a) % nbytes(s)) != 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] s);
    logic [31:0] r = '0;
    for (int i = 0; i < nbytes(s); i++) begin
      int k = int'(a) + i;
      if (rmem.exists(k)) r = r | (32'(rmem[k]) << (8 * i));
    end
    return r;
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] s);
    for (int i = 0; i < nbytes(s); i++) rmem[int'(a) + i] = wd[8*i +: 8];
  endtask

  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [1:0] sz, output logic [31:0] rd, output logic err,
                        output int cyc);
    int stall_bad = 0;
    bit got = 0;
    cyc = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_size = sz;
    while (!got && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (rsp_valid_o) begin
        got = 1;
        if (stall_o !== 1'b0) stall_bad++;
      end else if (stall_o !== 1'b1) stall_bad++;
    end
    rd = rsp_rdata_o;
    err = rsp_err_o;
    req_valid = 1'b0;
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL rsp_timeout: no rsp_valid after %0d cycles, required a response (addr=%h)", cyc, addr);
    end
    vectors++;
    if (stall_bad !== 0) begin
      miscompares++;
      $display("FAIL stall: %0d bad stall cycles, required 0 (addr=%h)", stall_bad, addr);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({stall_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, ps_addr_o, ps_write_en_o, ps_data_in_o,
         ps_write_high_byte_o, ps_write_low_byte_o, ps_read_en_o} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h, required 0", {stall_o, rsp_valid_o, rsp_rdata_o,
               rsp_err_o, ps_addr_o, ps_write_en_o, ps_data_in_o, ps_write_high_byte_o,
               ps_write_low_byte_o, ps_read_en_o});
    end
    vectors++;
    if (bank_sel_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_bank_sel: got %b, required 0", bank_sel_o);
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_word_store();
    logic [31:0] rd; logic err; int cyc;
    wr_busy = 4;
    wr_log.delete();
    do_req(1'b1, 32'h100, 32'hDEADBEEF, MASK_WORD, rd, err, cyc);
    ref_store(32'h100, 32'hDEADBEEF, MASK_WORD);
    vectors++;
    if (err !== 1'b0) begin miscompares++; $display("FAIL wstore_err: got %b, required 0", err); end
    vectors++;
    if (wr_log.size() !== 2) begin
      miscompares++; $display("FAIL wstore_count: got %0d writes, required 2", wr_log.size());
    end
    if (wr_log.size() >= 2) begin
      vectors++;
      if ({wr_log[0].a, wr_log[0].d, wr_log[0].hb, wr_log[0].lb} !== {22'h80, 16'hBEEF, 2'b11}) begin
        miscompares++;
        $display("FAIL wstore_lo: got a=%h d=%h hb=%b lb=%b, required a=80 d=beef hb=1 lb=1",
                 wr_log[0].a, wr_log[0].d, wr_log[0].hb, wr_log[0].lb);
      end
      vectors++;
      if ({wr_log[1].a, wr_log[1].d, wr_log[1].hb, wr_log[1].lb} !== {22'h81, 16'hDEAD, 2'b11}) begin
        miscompares++;
        $display("FAIL wstore_hi: got a=%h d=%h hb=%b lb=%b, required a=81 d=dead hb=1 lb=1",
                 wr_log[1].a, wr_log[1].d, wr_log[1].hb, wr_log[1].lb);
      end
    end
    wr_busy = 0;
  endtask

  task automatic test_word_load();
    logic [31:0] rd; logic err; int cyc, r0;
    rd_lat = 3;
    r0 = n_reads;
    do_req(1'b0, 32'h100, 32'h0, MASK_WORD, rd, err, cyc);
    vectors++;
    if (rd !== 32'hDEADBEEF || err !== 1'b0) begin
      miscompares++; $display("FAIL wload: got rdata=%h err=%b, required deadbeef err=0", rd, err);
    end
    vectors++;
    if (n_reads - r0 !== 2) begin
      miscompares++; $display("FAIL wload_reads: got %0d reads, required 2", n_reads - r0);
    end
    @(negedge clk);
    vectors++;
    if (rsp_valid_o !== 1'b0) begin
      miscompares++; $display("FAIL wload_pulse: rsp_valid %b a cycle after DONE, required 0", rsp_valid_o);
    end
  endtask

  task automatic test_byte();
    logic [31:0] rd; logic err; int cyc;
    wr_busy = 0;
    wr_log.delete();
    do_req(1'b1, 32'h203, 32'hFFFFFF5A, MASK_BYTE, rd, err, cyc);
    ref_store(32'h203, 32'hFFFFFF5A, MASK_BYTE);
    vectors++;
    if (wr_log.size() !== 1) begin
      miscompares++; $display("FAIL bstore_count: got %0d writes, required 1", wr_log.size());
    end
    if (wr_log.size() >= 1) begin
      vectors++;
      if ({wr_log[0].a, wr_log[0].d, wr_log[0].hb, wr_log[0].lb} !== {22'h101, 16'h5A5A, 2'b10}) begin
        miscompares++;
        $display("FAIL bstore_cmd: got a=%h d=%h hb=%b lb=%b, required a=101 d=5a5a hb=1 lb=0",
                 wr_log[0].a, wr_log[0].d, wr_log[0].hb, wr_log[0].lb);
      end
    end
    cmem[32'h101] = 16'h5A11;
    rmem[32'h202] = 8'h11;
    rd_lat = 2;
    do_req(1'b0, 32'h203, 32'h0, MASK_BYTE, rd, err, cyc);
    vectors++;
    if (rd !== 32'h0000005A || err !== 1'b0) begin
      miscompares++; $display("FAIL bload_odd: got rdata=%h err=%b, required 0000005a err=0", rd, err);
    end
    do_req(1'b0, 32'h202, 32'h0, MASK_BYTE, rd, err, cyc);
    vectors++;
    if (rd !== ref_load(32'h202, MASK_BYTE)) begin
      miscompares++; $display("FAIL bload_even: got rdata=%h, required %h", rd, ref_load(32'h202, MASK_BYTE));
    end
  endtask

  task automatic test_misaligned();
    logic [31:0] rd; logic err; int cyc, c0;
    c0 = n_writes + n_reads;
    do_req(1'b0, 32'h101, 32'h0, MASK_HALF, rd, err, cyc);
    vectors++;
    if (err !== 1'b1 || cyc !== 1) begin
      miscompares++; $display("FAIL mis_half: got err=%b cycles=%0d, required err=1 cycles=1", err, cyc);
    end
    do_req(1'b1, 32'h102, 32'h12345678, MASK_WORD, rd, err, cyc);
    vectors++;
    if (err !== 1'b1 || cyc !== 1) begin
      miscompares++; $display("FAIL mis_word: got err=%b cycles=%0d, required err=1 cycles=1", err, cyc);
    end
    vectors++;
    if (n_writes + n_reads - c0 !== 0) begin
      miscompares++; $display("FAIL mis_cmds: got %0d psram commands, required 0", n_writes + n_reads - c0);
    end
  endtask

  task automatic test_timeout();
    logic [31:0] rd; logic err; int cyc, r0;
    no_avail = 1;
    r0 = n_reads;
    do_req(1'b0, 32'h100, 32'h0, MASK_WORD, rd, err, cyc);
    vectors++;
    if (err !== 1'b1 || rd !== 32'h0) begin
      miscompares++; $display("FAIL tmo_rsp: got err=%b rdata=%h, required err=1 rdata=0", err, rd);
    end
    vectors++;
    if (cyc !== 2 + TMO) begin
      miscompares++; $display("FAIL tmo_latency: got %0d cycles, required %0d", cyc, 2 + TMO);
    end
    vectors++;
    if (n_reads - r0 !== 1) begin
      miscompares++; $display("FAIL tmo_reads: got %0d reads, required 1", n_reads - r0);
    end
    no_avail = 0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic err; int cyc, r0, seen;
    rd_lat = 10;
    r0 = n_reads;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h100; req_size = MASK_WORD;
    cyc = 0;
    while (n_reads - r0 < 2 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    vectors++;
    if (n_reads - r0 !== 2) begin
      miscompares++; $display("FAIL rst_reach_hi: got %0d reads, required 2", n_reads - r0);
    end
    reset_n = 1'b0;
    #1;
    vectors++;
    if ({stall_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, ps_addr_o, ps_write_en_o, ps_data_in_o,
         ps_write_high_byte_o, ps_write_low_byte_o, ps_read_en_o} !== '0) begin
      miscompares++; $display("FAIL rst_mid_outputs: nonzero outputs during reset, required 0");
    end
    req_valid = 1'b0;
    seen = 0;
    repeat (2) begin @(negedge clk); if (rsp_valid_o) seen++; end
    reset_n = 1'b1;
    repeat (4) begin @(negedge clk); if (rsp_valid_o) seen++; end
    vectors++;
    if (seen !== 0) begin
      miscompares++; $display("FAIL rst_mid_rsp: got %0d rsp_valid cycles, required 0", seen);
    end
    rd_lat = 3;
    do_req(1'b0, 32'h102, 32'h0, MASK_HALF, rd, err, cyc);
    vectors++;
    if (rd !== ref_load(32'h102, MASK_HALF) || err !== 1'b0) begin
      miscompares++; $display("FAIL rst_after_half: got rdata=%h err=%b, required %h err=0",
                              rd, err, ref_load(32'h102, MASK_HALF));
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic err; int cyc;
    wr_busy = 0;
    do_req(1'b1, 32'h301, 32'h000000A5, MASK_BYTE, rd, err, cyc);
    ref_store(32'h301, 32'h000000A5, MASK_BYTE);
    vectors++;
    if (cyc !== 3) begin miscompares++; $display("FAIL b2b_byte: got %0d cycles, required 3", cyc); end
    do_req(1'b1, 32'h306, 32'h0000C3D2, MASK_HALF, rd, err, cyc);
    ref_store(32'h306, 32'h0000C3D2, MASK_HALF);
    vectors++;
    if (cyc !== 3) begin miscompares++; $display("FAIL b2b_half: got %0d cycles, required 3", cyc); end
    do_req(1'b1, 32'h308, 32'h13579BDF, MASK_WORD, rd, err, cyc);
    ref_store(32'h308, 32'h13579BDF, MASK_WORD);
    vectors++;
    if (cyc !== 5) begin miscompares++; $display("FAIL b2b_word: got %0d cycles, required 5", cyc); end
    rd_lat = 1;
    do_req(1'b0, 32'h300, 32'h0, MASK_WORD, rd, err, cyc);
    vectors++;
    if (rd !== ref_load(32'h300, MASK_WORD)) begin
      miscompares++; $display("FAIL b2b_readback: got %h, required %h", rd, ref_load(32'h300, MASK_WORD));
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, addr, wd; logic err, we; logic [1:0] sz; int cyc, c0, exp_cmds;
    bit mis;
    for (int n = 0; n < 60; n++) begin
      we = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 2));
      addr = 32'h400 + 32'($urandom_range(0, 31));
      if ($urandom_range(0, 9) < 7) addr = addr & ~32'(nbytes(sz) - 1);
      wd = $urandom;
      wr_busy = $urandom_range(0, 5);
      rd_lat = $urandom_range(1, 5);
      mis = ref_misaligned(addr, sz);
      exp_cmds = mis ? 0 : (nbytes(sz) == 4 ? 2 : 1);
      c0 = n_writes + n_reads;
      do_req(we, addr, wd, sz, rd, err, cyc);
      vectors++;
      if (err !== mis) begin
        miscompares++; $display("FAIL rnd_err[%0d]: got %b, required %b (addr=%h size=%0d)", n, err, mis, addr, sz);
      end
      vectors++;
      if (n_writes + n_reads - c0 !== exp_cmds) begin
        miscompares++; $display("FAIL rnd_cmds[%0d]: got %0d, required %0d", n, n_writes + n_reads - c0, exp_cmds);
      end
      if (!we && !mis) begin
        vectors++;
        if (rd !== ref_load(addr, sz)) begin
          miscompares++; $display("FAIL rnd_rdata[%0d]: got %h, required %h (addr=%h size=%0d)",
                                  n, rd, ref_load(addr, sz), addr, sz);
        end
      end
      if (we && !mis) ref_store(addr, wd, sz);
    end
    vectors++;
    if (cmd_viol !== 0) begin
      miscompares++; $display("FAIL cmd_while_busy: got %0d commands issued while busy, required 0", cmd_viol);
    end
  endtask

  initial begin
    test_reset();
    test_word_store();
    test_word_load();
    test_byte();
    test_misaligned();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached before the summary");
    $fatal(1);
  end

endmodule
